// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle WIDTH-bit shifter, one single-bit shift per clock for a programmed amount.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (when undefined, op=11 behaves as logical right).
`timescale 1ns/1ps
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE or DONE; busy is high while shifting;
  // done is a one-cycle pulse during which dout/cout are final. A start in the
  // done cycle is accepted at that same edge (back-to-back).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_cnt;
  logic [1:0]       r_mode;

  logic [WIDTH-1:0] w_shift_dout;
  logic             w_shift_cout;

  always_comb begin
    w_shift_dout = r_dout;
    w_shift_cout = r_dout[0];
    case (r_mode)
      2'b00: begin
        w_shift_dout = {r_dout[WIDTH-2:0], 1'b0};
        w_shift_cout = r_dout[WIDTH-1];
      end
      2'b01: w_shift_dout = {1'b0, r_dout[WIDTH-1:1]};
      2'b10: w_shift_dout = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        w_shift_dout = {r_dout[0], r_dout[WIDTH-1:1]};
`else
        w_shift_dout = {1'b0, r_dout[WIDTH-1:1]};
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 4'd0;
      r_mode  <= 2'b00;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_dout <= w_shift_dout;
          r_cout <= w_shift_cout;
          r_cnt  <= r_cnt - 4'd1;
          // cnt is at least 1 here, so the decrement never wraps.
          if (r_cnt == 4'd1) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_dout <= din;
            r_cnt  <= amt;
            r_mode <= op;
            r_cout <= 1'b0;
            if (amt != 4'd0) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign cout      = r_cout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: random and directed shifts against an arithmetic reference model,
// with a done-driven scoreboard monitor. Honours SHIFT_SEQ_ROTATE_EN in the model.
`timescale 1ns/1ps
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  amt = 4'd0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        cout;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        exp_busy = 1'b0;
  logic        chk_reset = 1'b0;
  logic        end_req = 1'b0;

  shift_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .din(din),
    .dout(dout), .cout(cout), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: whole shift computed in one step with plain arithmetic.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [1:0] o,
                                        input logic [3:0] a);
    int n;
    logic [15:0] r;
    logic c;
    n = int'(a);
    if (n == 0) return {d, 1'b0};
    r = d >> n;
    c = d[n-1];
    case (o)
      2'b00: begin r = d << n; c = d[16-n]; end
      2'b10: r = 16'($signed(d) >>> n);
      2'b11: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        r = (d >> n) | (d << (16 - n));
`else
        r = d >> n;
`endif
      end
      default: r = d >> n;
    endcase
    return {r, c};
  endfunction

  // monitor / scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    int ec;
    if (chk_reset) begin
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_cout", 32'(cout), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
    end else if (!rst) begin
      check("busy", 32'(busy), 32'(exp_busy));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result_dout_cout", 32'({dout, cout}), 32'(e));
          check("done_cycle", 32'(cyc), 32'(ec));
        end
      end else if (exp_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        check("done_timeout", 32'(cyc), 32'(exp_cyc_q[0]));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
    if (end_req) check("queue_empty_at_end", 32'(exp_q.size()), 32'h0);
  end

  // drivers (called just after a rising edge, with the DUT in IDLE or DONE)
  task automatic run_op(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                        input bit pulse_during_shift);
    start = 1'b1; din = d; op = o; amt = a;
    @(posedge clk); #1;
    exp_q.push_back(model(d, o, a));
    exp_cyc_q.push_back(cyc + int'(a));
    exp_busy = (a != 4'd0);
    start = 1'b0; din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
    for (int k = 1; k <= int'(a); k++) begin
      if (pulse_during_shift && k == 1) begin
        start = 1'b1; din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      exp_busy = (k < int'(a));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic reset_check_cycle();
    chk_reset = 1'b1;
    @(negedge clk); #1;
    chk_reset = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_check_cycle();
    rst = 1'b0;
    idle_cycle();

    run_op(16'h8001, 2'b00, 4'd1, 1'b0);  idle_cycle();
    run_op(16'h8000, 2'b10, 4'd15, 1'b0); idle_cycle();
    run_op(16'h0003, 2'b11, 4'd4, 1'b0);  idle_cycle();
    run_op(16'h1234, 2'b00, 4'd0, 1'b0);
    run_op(16'h00F0, 2'b01, 4'd4, 1'b0);  idle_cycle();
    run_op(16'hA5C3, 2'b01, 4'd6, 1'b1);  idle_cycle();

    // Reset during the third shift of a 10-step operation: no done may follow.
    start = 1'b1; din = 16'hBEEF; op = 2'b00; amt = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    repeat (2) idle_cycle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_busy = 1'b0;
    reset_check_cycle();
    repeat (12) idle_cycle();

    for (int i = 0; i < 150; i++) begin
      run_op(16'($urandom), 2'($urandom), 4'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    repeat (3) idle_cycle();

    // final report
    end_req = 1'b1;
    @(negedge clk); #1;
    end_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
